// File: rtl/commit_trace_buffer_if.sv
// Commit trace buffer bus bundle.
//
// Groups the WB-stage commit tap, the capture controls, the trace drain
// handshake and the status counters into one bundle.
//   master : driver side (processor tap and trace reader)
//   slave  : the commit_trace_buffer itself
//
// Signals:
//   capture_en, clear            capture/count enable, synchronous clear pulse
//   mem_wb_valid_inst, mem_wb_IR WB-stage valid flag and instruction word
//   pipeline_commit_*            register-file write port (wr, idx, data, NPC)
//   trace_valid/trace_ready      head record handshake
//   trace_idx/data/npc           head record fields
//   trace_count                  FIFO occupancy
//   overflow, drop_count         sticky drop flag, saturating drop counter
//   retire_count, cycle_count    saturating retired-instruction / active-cycle counters
//   halted                       sticky halt-seen flag
interface commit_trace_buffer_if #(
  parameter int unsigned DEPTH = 16
) ();

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          capture_en;
  logic          clear;
  logic          mem_wb_valid_inst;
  logic [31:0]   mem_wb_IR;
  logic          pipeline_commit_wr;
  logic [4:0]    pipeline_commit_wr_idx;
  logic [31:0]   pipeline_commit_wr_data;
  logic [31:0]   pipeline_commit_NPC;

  logic          trace_valid;
  logic          trace_ready;
  logic [4:0]    trace_idx;
  logic [31:0]   trace_data;
  logic [31:0]   trace_npc;
  logic [CW-1:0] trace_count;
  logic          overflow;
  logic [15:0]   drop_count;
  logic [31:0]   retire_count;
  logic [31:0]   cycle_count;
  logic          halted;

  modport master (
    output capture_en, clear, mem_wb_valid_inst, mem_wb_IR,
           pipeline_commit_wr, pipeline_commit_wr_idx, pipeline_commit_wr_data,
           pipeline_commit_NPC, trace_ready,
    input  trace_valid, trace_idx, trace_data, trace_npc, trace_count,
           overflow, drop_count, retire_count, cycle_count, halted
  );

  modport slave (
    input  capture_en, clear, mem_wb_valid_inst, mem_wb_IR,
           pipeline_commit_wr, pipeline_commit_wr_idx, pipeline_commit_wr_data,
           pipeline_commit_NPC, trace_ready,
    output trace_valid, trace_idx, trace_data, trace_npc, trace_count,
           overflow, drop_count, retire_count, cycle_count, halted
  );

endinterface

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer.
//
// Taps the WB-stage commit port and records every architectural register
// write (x0 excluded) into a DEPTH-entry FIFO drained through a valid/ready
// reader. Also keeps saturating retired-instruction, active-cycle and
// dropped-record counters, and freezes capture once the halt instruction
// retires. Capture stays frozen until rst or clear; the FIFO remains drainable.
//
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset, overrides every other input
//   bus  commit_trace_buffer_if.slave (commit tap, controls, trace drain, status)
module commit_trace_buffer #(
  parameter int unsigned DEPTH     = 16,
  parameter logic [31:0] HALT_INST = 32'h0010_0073,
  parameter logic [31:0] NOOP_INST = 32'h0000_0013
) (
  input logic                  clk,
  input logic                  rst,
  commit_trace_buffer_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  // Record storage, no reset needed: only entries behind a valid count are read.
  logic [4:0]  mem_idx  [DEPTH];
  logic [31:0] mem_data [DEPTH];
  logic [31:0] mem_npc  [DEPTH];

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   drop_q, drop_d;
  logic [31:0]   retire_q, retire_d;
  logic [31:0]   cycle_q, cycle_d;
  logic          halted_q, halted_d;

  // Last popped record, shown on the head outputs while the FIFO is empty.
  logic [4:0]    last_idx_q, last_idx_d;
  logic [31:0]   last_data_q, last_data_d;
  logic [31:0]   last_npc_q, last_npc_d;

  logic active;
  logic push_req;
  logic pop;
  logic full;
  logic wr_en;
  logic drop;
  logic retire_hit;
  logic halt_hit;
  logic not_empty;

  logic [4:0]  head_idx;
  logic [31:0] head_data;
  logic [31:0] head_npc;

  // Control decode
  always_comb begin
    not_empty  = (count_q != '0);
    full       = (count_q == FullCount);
    active     = bus.capture_en & ~halted_q;
    push_req   = active & bus.mem_wb_valid_inst & bus.pipeline_commit_wr &
                 (bus.pipeline_commit_wr_idx != 5'd0);
    pop        = not_empty & bus.trace_ready & ~bus.clear;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    wr_en      = push_req & (~full | pop) & ~bus.clear;
    drop       = push_req & full & ~pop & ~bus.clear;
    retire_hit = active & bus.mem_wb_valid_inst & (bus.mem_wb_IR != NOOP_INST);
    halt_hit   = active & bus.mem_wb_valid_inst & (bus.mem_wb_IR == HALT_INST);
    head_idx   = mem_idx[rptr_q];
    head_data  = mem_data[rptr_q];
    head_npc   = mem_npc[rptr_q];
  end

  // Next-state
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    drop_d      = drop_q;
    retire_d    = retire_q;
    cycle_d     = cycle_q;
    halted_d    = halted_q;
    last_idx_d  = last_idx_q;
    last_data_d = last_data_q;
    last_npc_d  = last_npc_q;

    if (bus.clear) begin
      wptr_d      = '0;
      rptr_d      = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      drop_d      = '0;
      retire_d    = '0;
      cycle_d     = '0;
      halted_d    = 1'b0;
      last_idx_d  = '0;
      last_data_d = '0;
      last_npc_d  = '0;
    end else begin
      if (wr_en) begin
        wptr_d = wptr_q + AW'(1);
      end
      if (pop) begin
        rptr_d      = rptr_q + AW'(1);
        last_idx_d  = head_idx;
        last_data_d = head_data;
        last_npc_d  = head_npc;
      end

      unique case ({wr_en, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase

      if (drop) begin
        overflow_d = 1'b1;
        if (drop_q != 16'hFFFF) begin
          drop_d = drop_q + 16'd1;
        end
      end

      if (retire_hit && (retire_q != 32'hFFFF_FFFF)) begin
        retire_d = retire_q + 32'd1;
      end
      if (active && (cycle_q != 32'hFFFF_FFFF)) begin
        cycle_d = cycle_q + 32'd1;
      end
      // Push above already used the pre-halt active, so the halt itself is recorded.
      if (halt_hit) begin
        halted_d = 1'b1;
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      drop_q      <= '0;
      retire_q    <= '0;
      cycle_q     <= '0;
      halted_q    <= 1'b0;
      last_idx_q  <= '0;
      last_data_q <= '0;
      last_npc_q  <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      drop_q      <= drop_d;
      retire_q    <= retire_d;
      cycle_q     <= cycle_d;
      halted_q    <= halted_d;
      last_idx_q  <= last_idx_d;
      last_data_q <= last_data_d;
      last_npc_q  <= last_npc_d;
    end
  end

  // Record storage write port
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem_idx[wptr_q]  <= bus.pipeline_commit_wr_idx;
      mem_data[wptr_q] <= bus.pipeline_commit_wr_data;
      mem_npc[wptr_q]  <= bus.pipeline_commit_NPC;
    end
  end

  // Outputs
  always_comb begin
    bus.trace_valid  = not_empty;
    bus.trace_idx    = not_empty ? head_idx  : last_idx_q;
    bus.trace_data   = not_empty ? head_data : last_data_q;
    bus.trace_npc    = not_empty ? head_npc  : last_npc_q;
    bus.trace_count  = count_q;
    bus.overflow     = overflow_q;
    bus.drop_count   = drop_q;
    bus.retire_count = retire_q;
    bus.cycle_count  = cycle_q;
    bus.halted       = halted_q;
  end

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Downstream consumer of the processor's WB-stage commit port: records every architectural register write into a FIFO for debug/testbench readout.
- Keeps retired-instruction and cycle counters, and detects the halt instruction to freeze capture.
- Sits beside the processor top; taps pipeline_commit_*, mem_wb_valid_inst and mem_wb_IR; drained by a valid/ready reader.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, 2..256.
- HALT_INST, 32'h0010_0073, IR value that freezes capture (EBREAK).
- NOOP_INST, 32'h0000_0013, IR value excluded from the retire count.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- capture_en  in  1  global capture/count enable.
- clear  in  1  one-cycle pulse: empties the FIFO and zeroes counters and sticky flags.
- mem_wb_valid_inst  in  1  WB stage holds a valid instruction.
- mem_wb_IR  in  32  WB-stage instruction word.
- pipeline_commit_wr  in  1  register-file write this cycle.
- pipeline_commit_wr_idx  in  5  destination register.
- pipeline_commit_wr_data  in  32  write data.
- pipeline_commit_NPC  in  32  NPC tag stored with the record.
- trace_valid  out  1  head record available.
- trace_ready  in  1  reader accepts the head record.
- trace_idx  out  5  head record register index.
- trace_data  out  32  head record data.
- trace_npc  out  32  head record NPC.
- trace_count  out  $clog2(DEPTH)+1  occupancy.
- overflow  out  1  sticky; a record was dropped.
- drop_count  out  16  dropped records, saturating.
- retire_count  out  32  retired instructions, saturating.
- cycle_count  out  32  active cycles, saturating.
- halted  out  1  sticky halt seen.

Behaviour:
- Reset (rst=1 at posedge):
  - trace_valid=0, trace_count=0, overflow=0, drop_count=0, retire_count=0, cycle_count=0, halted=0.
  - trace_idx/data/npc=0; read/write pointers=0.
  - rst overrides clear and every other input, including mid-drain.
- clear:
  - Same effect as reset on all state.
  - A push or pop in the same cycle is ignored.
- active = capture_en & ~halted.
- push = active & mem_wb_valid_inst & pipeline_commit_wr & (pipeline_commit_wr_idx != 0).
  - x0 writes are never recorded.
- pop = trace_valid & trace_ready.
- Push:
  - Not full: record written at wptr; wptr increments modulo DEPTH.
  - Record is visible at the head no earlier than the cycle after the push edge (1-cycle latency, no same-cycle bypass).
- Full and push:
  - With pop in the same cycle: both occur, occupancy stays DEPTH, no drop.
  - Without pop: record discarded; overflow<=1; drop_count += 1, saturating at 16'hFFFF.
- Empty and pop: impossible (trace_valid=0); trace_ready is ignored.
- Pop: rptr increments modulo DEPTH.
  - Head outputs show the entry at rptr, stable while trace_valid=1 & trace_ready=0.
  - Head outputs hold their last value when empty.
- trace_count:
  - +1 on push only, -1 on pop only, unchanged on both.
  - trace_valid = (trace_count != 0).
  - Pointers wrap cleanly across DEPTH boundaries.
- retire_count += 1 when active & mem_wb_valid_inst & mem_wb_IR != NOOP_INST; saturates at 32'hFFFFFFFF.
- cycle_count += 1 each cycle while active; saturates at 32'hFFFFFFFF.
- Halt:
  - Triggered when active & mem_wb_valid_inst & mem_wb_IR == HALT_INST.
  - The halt instruction itself counts as retired and is recorded if it writes a register (push evaluated with the pre-halt active).
  - halted<=1 from the next cycle; thereafter no push and no counting.
  - The FIFO remains drainable while halted.
  - halted clears only on rst or clear.
- capture_en=0: no push and no counting; pops still proceed.

Test Plan:
- Reset: apply rst with the FIFO holding 3 entries -> next cycle trace_valid=0, trace_count=0, all counters 0, halted=0.
- Single capture: commit wr=1, idx=5, data=32'hDEADBEEF, NPC=32'h104, valid=1, IR=32'h00500293 -> following cycle trace_valid=1, trace_idx=5, trace_data=DEADBEEF, trace_npc=104, retire_count=1; trace_ready=1 -> trace_valid=0.
- x0 filter: commit idx=0, wr=1, valid=1 with a non-NOP IR -> no record, retire_count increments.
- Overflow: 17 pushes with trace_ready=0 -> trace_count=16, overflow=1, drop_count=1; then pop 16 -> records 1..16 in order, wptr/rptr wrapped to 0.
- Full with simultaneous push+pop: FIFO full, push and trace_ready=1 in the same cycle -> trace_count stays 16, drop_count unchanged, new record at the tail.
- Halt: IR=32'h00100073 valid after 10 active cycles -> halted=1 next cycle, cycle_count frozen at 11, later commits not recorded, FIFO still drains; clear pulse -> all zero, capture resumes.
